lc3_ctrl: RTL
=============

LC3_CTRL -- requirements
Module: lc3_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: max consecutive cycles a memory access may wait for mem_ready before the ERROR state is entered.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ir  input  16  current instruction register contents from the datapath.
REQ-005 SHALL have port nzp  input  3  condition codes {N,Z,P} from the datapath.
REQ-006 SHALL have port mem_ready  input  1  memory completes the access in this cycle.
REQ-007 SHALL have ports ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc  output  1 each  datapath register load enables.
REQ-008 SHALL have ports gate_pc, gate_mdr, gate_alu, gate_marmux  output  1 each  bus drivers; at most one high per cycle.
REQ-009 SHALL have port pcmux_sel  output  2  PC source: 0 = PC+1, 1 = address adder, 2 = base register (JMP).
REQ-010 SHALL have port alu_op  output  2  0 = ADD, 1 = AND, 2 = NOT, 3 = pass A.
REQ-011 SHALL have ports mem_en, mem_we  output  1 each  memory request and write qualifier.
REQ-012 SHALL have ports halt, illegal  output  1 each  sticky stop indicators.

Function
REQ-013 SHALL be a Moore FSM with states FETCH0, FETCH1, FETCH2, DECODE, EXEC_ALU, EXEC_BR, EXEC_JMP, EXEC_LEA, ADDR, MEM_RD, MEM_WR, WB, HALT, ERROR; all outputs decode from state except ld_mdr.
REQ-014 FETCH0 SHALL assert gate_pc, ld_mar, ld_pc with pcmux_sel=0; the next state is FETCH1.
REQ-015 FETCH1 and MEM_RD SHALL hold mem_en=1, mem_we=0 until mem_ready=1; ld_mdr SHALL equal (state is FETCH1 or MEM_RD) AND mem_ready.
REQ-016 FETCH2 SHALL assert gate_mdr and ld_ir; DECODE SHALL dispatch on ir[15:12].
REQ-017 ADD 0001, AND 0101, NOT 1001 SHALL go to EXEC_ALU: gate_alu, ld_reg, ld_cc, alu_op per opcode; then FETCH0.
REQ-018 BR 0000 SHALL go to EXEC_BR: ld_pc with pcmux_sel=1 only if (ir[11:9] AND nzp) != 0; ir[11:9]=000 is never taken; then FETCH0.
REQ-019 JMP 1100 SHALL go to EXEC_JMP: ld_pc with pcmux_sel=2; LEA 1110 SHALL go to EXEC_LEA: gate_marmux, ld_reg, ld_cc=0; both then FETCH0.
REQ-020 LD 0010, LDR 0110, ST 0011, STR 0111 SHALL pass through ADDR (gate_marmux, ld_mar); loads continue MEM_RD -> WB (gate_mdr, ld_reg, ld_cc) -> FETCH0.
REQ-021 Stores SHALL go ADDR -> MEM_WR: mem_en=1, mem_we=1, gate_alu, alu_op=3, held until mem_ready=1, then FETCH0.
REQ-022 TRAP 1111 SHALL enter HALT; all other opcodes (0100, 1000, 1010, 1011, 1101) SHALL enter HALT with illegal=1.
REQ-023 HALT and ERROR SHALL be terminal until reset; all enables low; halt=1; ERROR also sets illegal=1.
REQ-024 A wait counter SHALL count cycles with mem_en=1 and mem_ready=0; it clears on mem_ready or leaving a memory state; reaching MEM_WAIT_MAX SHALL force ERROR on the next edge.
REQ-025 With mem_ready=1 on first request, latencies SHALL be: ADD/AND/NOT/BR/JMP/LEA 5 cycles; LD/LDR 7 cycles; ST/STR 6 cycles (FETCH0 to next FETCH0).
REQ-026 mem_ready while mem_en=0 SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force state FETCH0, clear the wait counter, halt and illegal; all outputs except the FETCH0 Moore outputs SHALL be 0.
REQ-028 Reset during MEM_RD/MEM_WR SHALL drop mem_en and mem_we in the same cycle, without waiting for a clock edge.
REQ-029 The first FETCH0 actions SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-030 Package lc3_pkg SHALL hold the opcode constants, the state enumeration, and the pcmux_sel and alu_op encodings.
REQ-031 The wait/timeout counter SHALL be sub-module lc3_ctrl_memwait (inputs clk, rst, active, ready; output timeout).

Verification
REQ-032 Reset, then ir=0x1021 (ADD R0,R0,#1) with mem_ready always 1 -> EXEC_ALU reached in cycle 5; ld_reg=ld_cc=1, alu_op=0; back in FETCH0 in cycle 6.
REQ-033 ir=0x0A03 (BRnp) with nzp=010 -> no ld_pc in EXEC_BR; with nzp=100 -> ld_pc=1, pcmux_sel=1.
REQ-034 ir=0x2005 (LD) with mem_ready delayed 3 cycles in MEM_RD -> mem_en held 4 cycles; ld_mdr pulses once; WB follows.
REQ-035 mem_ready held 0 in FETCH1 with MEM_WAIT_MAX=15 -> ERROR after 15 wait cycles; halt=illegal=1; mem_en=0.
REQ-036 ir=0xF025 (TRAP) -> HALT with illegal=0; ir=0xD000 -> HALT with illegal=1; both stay put for 20 cycles.
REQ-037 rst pulsed low mid-MEM_WR -> mem_en/mem_we drop immediately; FETCH0 resumes after release.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 control unit: opcodes, FSM states and
// the datapath select codes driven on pcmux_sel and alu_op.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] PC_INC   = 2'd0;
   localparam logic [1:0] PC_ADDER = 2'd1;
   localparam logic [1:0] PC_BASE  = 2'd2;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_AND   = 2'd1;
   localparam logic [1:0] ALU_NOT   = 2'd2;
   localparam logic [1:0] ALU_PASSA = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH0   = 4'd0,
      S_FETCH1   = 4'd1,
      S_FETCH2   = 4'd2,
      S_DECODE   = 4'd3,
      S_EXEC_ALU = 4'd4,
      S_EXEC_BR  = 4'd5,
      S_EXEC_JMP = 4'd6,
      S_EXEC_LEA = 4'd7,
      S_ADDR     = 4'd8,
      S_MEM_RD   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_WB       = 4'd11,
      S_HALT     = 4'd12,
      S_ERROR    = 4'd13
   } state_e;

endpackage

// File: rtl/lc3_ctrl_memwait.sv
// Memory wait watchdog: counts consecutive stalled cycles of an active
// access and flags the cycle in which the stall budget is used up.
module lc3_ctrl_memwait #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic timeout
);
   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          stall_s;

   assign stall_s = active & ~ready;
   // cnt_q holds stalls already completed, so the current stall is the last allowed one
   assign timeout = stall_s & (cnt_q == CW'(MEM_WAIT_MAX - 1));

   // next count: advance on a stall, otherwise restart
   always_comb begin
      cnt_d = '0;
      if (stall_s) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // stall counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lc3_ctrl.sv
// LC-3 multicycle control FSM: Moore decode of datapath enables from the
// state register, with a memory-stall watchdog that traps into ERROR.
module lc3_ctrl
   import lc3_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic [2:0]  nzp,
   input  logic        mem_ready,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_pc,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic        gate_pc,
   output logic        gate_mdr,
   output logic        gate_alu,
   output logic        gate_marmux,
   output logic [1:0]  pcmux_sel,
   output logic [1:0]  alu_op,
   output logic        mem_en,
   output logic        mem_we,
   output logic        halt,
   output logic        illegal
);
   state_e     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       mem_state_s;
   logic       timeout_s;
   logic [3:0] opcode_s;
   logic       unused_s;

   assign opcode_s    = ir[15:12];
   assign unused_s    = ^ir[8:0];
   assign mem_state_s = (state_q == S_FETCH1) | (state_q == S_MEM_RD) | (state_q == S_MEM_WR);
   assign illegal     = illegal_q;

   lc3_ctrl_memwait #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_memwait (
      .clk     (clk),
      .rst     (rst),
      .active  (mem_state_s),
      .ready   (mem_ready),
      .timeout (timeout_s)
   );

   // state and sticky illegal flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // next-state and Moore output decode
   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      ld_mar      = 1'b0;
      ld_mdr      = 1'b0;
      ld_ir       = 1'b0;
      ld_pc       = 1'b0;
      ld_reg      = 1'b0;
      ld_cc       = 1'b0;
      gate_pc     = 1'b0;
      gate_mdr    = 1'b0;
      gate_alu    = 1'b0;
      gate_marmux = 1'b0;
      pcmux_sel   = PC_INC;
      alu_op      = ALU_ADD;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      halt        = 1'b0;
      case (state_q)
         S_FETCH0: begin
            gate_pc = 1'b1;
            ld_mar  = 1'b1;
            ld_pc   = 1'b1;
            state_d = S_FETCH1;
         end
         S_FETCH1, S_MEM_RD: begin
            mem_en = 1'b1;
            ld_mdr = mem_ready;
            if (mem_ready) begin
               state_d = (state_q == S_FETCH1) ? S_FETCH2 : S_WB;
            end else if (timeout_s) begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH2: begin
            gate_mdr = 1'b1;
            ld_ir    = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            case (opcode_s)
               OP_ADD, OP_AND, OP_NOT:    state_d = S_EXEC_ALU;
               OP_BR:                     state_d = S_EXEC_BR;
               OP_JMP:                    state_d = S_EXEC_JMP;
               OP_LEA:                    state_d = S_EXEC_LEA;
               OP_LD, OP_LDR, OP_ST, OP_STR: state_d = S_ADDR;
               OP_TRAP:                   state_d = S_HALT;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC_ALU: begin
            gate_alu = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
            case (opcode_s)
               OP_AND:  alu_op = ALU_AND;
               OP_NOT:  alu_op = ALU_NOT;
               default: alu_op = ALU_ADD;
            endcase
            state_d = S_FETCH0;
         end
         S_EXEC_BR: begin
            // an all-zero condition field never matches, so it is never taken
            if ((ir[11:9] & nzp) != 3'b000) begin
               ld_pc     = 1'b1;
               pcmux_sel = PC_ADDER;
            end else begin
               ld_pc     = 1'b0;
            end
            state_d = S_FETCH0;
         end
         S_EXEC_JMP: begin
            ld_pc     = 1'b1;
            pcmux_sel = PC_BASE;
            state_d   = S_FETCH0;
         end
         S_EXEC_LEA: begin
            gate_marmux = 1'b1;
            ld_reg      = 1'b1;
            state_d     = S_FETCH0;
         end
         S_ADDR: begin
            gate_marmux = 1'b1;
            ld_mar      = 1'b1;
            // opcode bit 12 separates stores (ST/STR) from loads (LD/LDR)
            if (ir[12]) begin
               state_d = S_MEM_WR;
            end else begin
               state_d = S_MEM_RD;
            end
         end
         S_MEM_WR: begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            gate_alu = 1'b1;
            alu_op   = ALU_PASSA;
            if (mem_ready) begin
               state_d = S_FETCH0;
            end else if (timeout_s) begin
               state_d   = S_ERROR;
               illegal_d = 1'b1;
            end else begin
               state_d = S_MEM_WR;
            end
         end
         S_WB: begin
            gate_mdr = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
            state_d  = S_FETCH0;
         end
         S_HALT, S_ERROR: begin
            halt    = 1'b1;
            state_d = state_q;
         end
         default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
         end
      endcase
   end

endmodule
